multicycle_control: RTL and testbench
=====================================

# multicycle_control

- Multicycle MIPS main control FSM; sits directly upstream of the ALU control decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback.
- Drives the datapath strobes and mux selects, and supplies the 3-bit `ALUOp` the ALU control decoder turns into `ALUCtl`.
- Stalls on a memory ready handshake.

## Interface
Parameters: none. Opcode and ALUOp encodings are fixed constants in the shared package.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `opcode` in 6: IR[31:26], held stable by the IR from DECODE onward.
- `mem_ready` in 1: memory has completed the current access this cycle.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load if branch condition true.
- `branch_ne` out 1: invert zero test (bne).
- `iord` out 1: memory address source, 0 = PC, 1 = ALUOut.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `ir_write` out 1: load IR.
- `mem_to_reg` out 1: writeback source, 1 = MDR.
- `reg_dst` out 1: destination register, 1 = rd, 0 = rt.
- `reg_write` out 1: register file write.
- `zero_ext` out 1: zero-extend immediate (andi/ori).
- `alu_src_a` out 1: ALU A input, 0 = PC, 1 = A.
- `alu_src_b` out 2: ALU B input, 00 = B, 01 = 4, 10 = imm, 11 = imm<<2.
- `pc_source` out 2: PC source, 00 = ALU, 01 = ALUOut, 10 = jump target.
- `alu_op` out 3: 000 add, 001 sub, 010 R-type, 100 and, 101 or, 110 bgtz, 111 slt.
- `illegal_op` out 1: one-cycle pulse on unsupported opcode.

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, R_WB, BRANCH, IMM_EXEC, IMM_WB, JUMP.
- Outputs are a function of state, plus `mem_ready` for the FETCH strobes and `opcode` for BRANCH/IMM_EXEC selects.
- All outputs not listed for a state are 0.
- FETCH: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=000, `pc_source`=00.
  - `ir_write` and `pc_write` are 1 only when `mem_ready`=1.
  - Advances to DECODE on `mem_ready`, otherwise stays in FETCH.
- DECODE: `alu_src_b`=11, `alu_op`=000 (branch target into ALUOut). Next state by opcode:
  - R-type 000000 → EXEC_R
  - lw 100011 / sw 101011 → MEM_ADDR
  - beq 000100 / bne 000101 / bgtz 000111 → BRANCH
  - addi 001000 / slti 001010 / andi 001100 / ori 001101 → IMM_EXEC
  - j 000010 → JUMP
  - anything else → FETCH, with `illegal_op`=1 for that cycle
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=000; next state MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: `mem_read`=1, `iord`=1; holds until `mem_ready`, then MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0; next state FETCH.
- MEM_WRITE: `mem_write`=1, `iord`=1; holds until `mem_ready`, then FETCH.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=010; next state R_WB.
- R_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0; next state FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `pc_write_cond`=1, `pc_source`=01; next state FETCH.
  - `alu_op`=001 for beq/bne, 110 for bgtz.
  - `branch_ne`=1 only for bne.
- IMM_EXEC: `alu_src_a`=1, `alu_src_b`=10; next state IMM_WB.
  - `alu_op` is 000 addi, 111 slti, 100 andi, 101 ori.
  - `zero_ext`=1 for andi/ori.
- IMM_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0; `zero_ext` as in IMM_EXEC; next state FETCH.
- JUMP: `pc_write`=1, `pc_source`=10; next state FETCH.
- `mem_ready` is ignored outside FETCH, MEM_READ and MEM_WRITE.

## Timing
- Reset:
  - Any edge with `rst_n`=0 loads FETCH, from any state, including mid-stall.
  - While `rst_n`=0, all strobes (`pc_write`, `pc_write_cond`, `ir_write`, `mem_read`, `mem_write`, `reg_write`, `illegal_op`) are forced 0.
  - All other outputs are 0 during reset.
  - First fetch begins the cycle after `rst_n` rises.
- Latency, in cycles with `mem_ready` tied high:
  - R-type 4, lw 5, sw 4, branch 3, immediate 4, j 3, illegal 2.
- Each low-`mem_ready` cycle in FETCH, MEM_READ or MEM_WRITE adds one cycle; strobes stay asserted throughout the stall.
- `illegal_op` is high for exactly one cycle (in DECODE).
- A `pc_write` + `ir_write` pair occurs exactly once per instruction.

## Structure
- Package `mips_ctl_pkg`:
  - state enum
  - opcode constants
  - `alu_op` encodings (shared with the ALU control decoder)
  - `alu_src_b` / `pc_source` select constants
- One natural sub-module, `mc_output_decode`: combinational state+opcode→control-word table.
- State register and next-state logic stay in `multicycle_control`.

## Test plan
- add (opcode 000000), `mem_ready`=1 → FETCH, DECODE, EXEC_R (`alu_op`=010), R_WB (`reg_write`=1, `reg_dst`=1); next FETCH at cycle 5.
- lw 100011, `mem_ready` low 2 cycles in MEM_READ → 7 cycles total; `iord`=1 and `mem_read`=1 for 3 cycles; MEM_WB has `mem_to_reg`=1.
- beq / bne / bgtz → BRANCH with `alu_op` 001/001/110, `branch_ne` 0/1/0, `pc_write_cond`=1, `pc_source`=01; back to FETCH after 3 cycles.
- andi 001100, then slti 001010 → `alu_op` 100 with `zero_ext`=1, then `alu_op` 111 with `zero_ext`=0; `reg_dst`=0 in IMM_WB.
- opcode 111111 → `illegal_op` one-cycle pulse in DECODE; FETCH next; no `reg_write`/`mem_write`.
- sw stalled in MEM_WRITE, `rst_n`=0 for one cycle → `mem_write` 0 that cycle; FETCH after reset; `pc_write` only once `mem_ready` returns.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM and the ALU control decoder.
package mips_ctl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXEC_R,
        S_R_WB,
        S_BRANCH,
        S_IMM_EXEC,
        S_IMM_WB,
        S_JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_BGTZ  = 3'b110;
    localparam logic [2:0] ALU_SLT   = 3'b111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       zero_ext;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       illegal_op;
    } ctl_t;

    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_BGTZ, OP_ADDI,
            OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        case (op)
            OP_SLTI: return ALU_SLT;
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Opcode/ready inputs and datapath control word between the main control FSM and the datapath.
interface multicycle_control_if;

    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       zero_ext;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       illegal_op;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, zero_ext, alu_src_a,
               alu_src_b, pc_source, alu_op, illegal_op
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, zero_ext, alu_src_a,
               alu_src_b, pc_source, alu_op, illegal_op
    );

endinterface

// File: rtl/multicycle_control_output_decode.sv
// Combinational state+opcode to control-word table for the multicycle control FSM.
module mc_output_decode
    import mips_ctl_pkg::*;
(
    input  state_t     i_state,
    input  logic [5:0] i_opcode,
    input  logic       i_mem_ready,
    output ctl_t       o_ctl
);

    logic w_zext;
    assign w_zext = (i_opcode == OP_ANDI) || (i_opcode == OP_ORI);

    always_comb begin
        o_ctl = '0;
        unique case (i_state)
            S_FETCH: begin
                o_ctl.mem_read  = 1'b1;
                o_ctl.alu_src_b = SRCB_FOUR;
                o_ctl.alu_op    = ALU_ADD;
                o_ctl.pc_source = PCSRC_ALU;
                o_ctl.ir_write  = i_mem_ready;
                o_ctl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_ctl.alu_src_b  = SRCB_IMM_SH;
                o_ctl.alu_op     = ALU_ADD;
                o_ctl.illegal_op = ~is_legal(i_opcode);
            end
            S_MEM_ADDR: begin
                o_ctl.alu_src_a = 1'b1;
                o_ctl.alu_src_b = SRCB_IMM;
                o_ctl.alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                o_ctl.mem_read = 1'b1;
                o_ctl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                o_ctl.reg_write  = 1'b1;
                o_ctl.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                o_ctl.mem_write = 1'b1;
                o_ctl.iord      = 1'b1;
            end
            S_EXEC_R: begin
                o_ctl.alu_src_a = 1'b1;
                o_ctl.alu_src_b = SRCB_B;
                o_ctl.alu_op    = ALU_RTYPE;
            end
            S_R_WB: begin
                o_ctl.reg_write = 1'b1;
                o_ctl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                o_ctl.alu_src_a     = 1'b1;
                o_ctl.alu_src_b     = SRCB_B;
                o_ctl.pc_write_cond = 1'b1;
                o_ctl.pc_source     = PCSRC_ALUOUT;
                o_ctl.alu_op        = (i_opcode == OP_BGTZ) ? ALU_BGTZ : ALU_SUB;
                o_ctl.branch_ne     = (i_opcode == OP_BNE);
            end
            S_IMM_EXEC: begin
                o_ctl.alu_src_a = 1'b1;
                o_ctl.alu_src_b = SRCB_IMM;
                o_ctl.alu_op    = imm_alu_op(i_opcode);
                o_ctl.zero_ext  = w_zext;
            end
            S_IMM_WB: begin
                o_ctl.reg_write = 1'b1;
                o_ctl.zero_ext  = w_zext;
            end
            S_JUMP: begin
                o_ctl.pc_write  = 1'b1;
                o_ctl.pc_source = PCSRC_JUMP;
            end
            default: o_ctl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM: state register, next-state logic and reset gating of the control word.
module multicycle_control
    import mips_ctl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);

    state_t r_state;
    ctl_t   w_ctl;
    ctl_t   w_out;

    mc_output_decode u_decode (
        .i_state     (r_state),
        .i_opcode    (bus.opcode),
        .i_mem_ready (bus.mem_ready),
        .o_ctl       (w_ctl)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:     if (bus.mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (bus.opcode)
                        OP_RTYPE:                     r_state <= S_EXEC_R;
                        OP_LW, OP_SW:                 r_state <= S_MEM_ADDR;
                        OP_BEQ, OP_BNE, OP_BGTZ:      r_state <= S_BRANCH;
                        OP_ADDI, OP_SLTI,
                        OP_ANDI, OP_ORI:              r_state <= S_IMM_EXEC;
                        OP_J:                         r_state <= S_JUMP;
                        default:                      r_state <= S_FETCH;
                    endcase
                end
                S_MEM_ADDR:  r_state <= (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ:  if (bus.mem_ready) r_state <= S_MEM_WB;
                S_MEM_WRITE: if (bus.mem_ready) r_state <= S_FETCH;
                S_EXEC_R:    r_state <= S_R_WB;
                S_IMM_EXEC:  r_state <= S_IMM_WB;
                default:     r_state <= S_FETCH;
            endcase
        end
    end

    // Reset is synchronous for the state, but the outputs are held low combinationally while rst_n is low.
    assign w_out = rst_n ? w_ctl : '0;

    assign bus.pc_write      = w_out.pc_write;
    assign bus.pc_write_cond = w_out.pc_write_cond;
    assign bus.branch_ne     = w_out.branch_ne;
    assign bus.iord          = w_out.iord;
    assign bus.mem_read      = w_out.mem_read;
    assign bus.mem_write     = w_out.mem_write;
    assign bus.ir_write      = w_out.ir_write;
    assign bus.mem_to_reg    = w_out.mem_to_reg;
    assign bus.reg_dst       = w_out.reg_dst;
    assign bus.reg_write     = w_out.reg_write;
    assign bus.zero_ext      = w_out.zero_ext;
    assign bus.alu_src_a     = w_out.alu_src_a;
    assign bus.alu_src_b     = w_out.alu_src_b;
    assign bus.pc_source     = w_out.pc_source;
    assign bus.alu_op        = w_out.alu_op;
    assign bus.illegal_op    = w_out.illegal_op;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: latency table, corner-case sequences and a random instruction stream.
module tb_multicycle_control;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       zero_ext;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       illegal_op;
    } cw_t;

    typedef struct {
        logic [5:0] op;
        int         lat;
        int         regw;
        int         memw;
        int         ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_total = 0;
    int   n_pass  = 0;
    cw_t  cw;

    cw_t  m_step[8];
    bit   m_wait[8];
    int   m_n;

    always #5 clk = ~clk;

    multicycle_control_if bus();

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic cw_t sample();
        cw_t s;
        s.pc_write      = bus.pc_write;
        s.pc_write_cond = bus.pc_write_cond;
        s.branch_ne     = bus.branch_ne;
        s.iord          = bus.iord;
        s.mem_read      = bus.mem_read;
        s.mem_write     = bus.mem_write;
        s.ir_write      = bus.ir_write;
        s.mem_to_reg    = bus.mem_to_reg;
        s.reg_dst       = bus.reg_dst;
        s.reg_write     = bus.reg_write;
        s.zero_ext      = bus.zero_ext;
        s.alu_src_a     = bus.alu_src_a;
        s.alu_src_b     = bus.alu_src_b;
        s.pc_source     = bus.pc_source;
        s.alu_op        = bus.alu_op;
        s.illegal_op    = bus.illegal_op;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input bit rdy, input logic [5:0] op);
        bus.mem_ready = rdy;
        bus.opcode    = op;
        #4;
        cw = sample();
    endtask

    task automatic push(input cw_t c, input bit w);
        m_step[m_n] = c;
        m_wait[m_n] = w;
        m_n++;
    endtask

    // Reference: the expected control-word sequence for one instruction, built from its class.
    task automatic plan(input logic [5:0] op);
        cw_t c;
        bit  legal;
        bit  zx;
        legal = op inside {6'd0, 6'd2, 6'd4, 6'd5, 6'd7, 6'd8, 6'd10, 6'd12, 6'd13, 6'd35, 6'd43};
        m_n = 0;
        c = '0; c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = 1; c.pc_write = 1; push(c, 1);
        c = '0; c.alu_src_b = 2'b11; c.illegal_op = !legal; push(c, 0);
        if (op == 6'd0) begin
            c = '0; c.alu_src_a = 1; c.alu_op = 3'b010; push(c, 0);
            c = '0; c.reg_write = 1; c.reg_dst = 1; push(c, 0);
        end else if (op == 6'd35 || op == 6'd43) begin
            c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10; push(c, 0);
            if (op == 6'd35) begin
                c = '0; c.mem_read = 1; c.iord = 1; push(c, 1);
                c = '0; c.reg_write = 1; c.mem_to_reg = 1; push(c, 0);
            end else begin
                c = '0; c.mem_write = 1; c.iord = 1; push(c, 1);
            end
        end else if (op inside {6'd4, 6'd5, 6'd7}) begin
            c = '0; c.alu_src_a = 1; c.pc_write_cond = 1; c.pc_source = 2'b01;
            c.alu_op = (op == 6'd7) ? 3'b110 : 3'b001;
            c.branch_ne = (op == 6'd5);
            push(c, 0);
        end else if (op inside {6'd8, 6'd10, 6'd12, 6'd13}) begin
            zx = (op == 6'd12) || (op == 6'd13);
            c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10; c.zero_ext = zx;
            case (op)
                6'd10:   c.alu_op = 3'b111;
                6'd12:   c.alu_op = 3'b100;
                6'd13:   c.alu_op = 3'b101;
                default: c.alu_op = 3'b000;
            endcase
            push(c, 0);
            c = '0; c.reg_write = 1; c.zero_ext = zx; push(c, 0);
        end else if (op == 6'd2) begin
            c = '0; c.pc_write = 1; c.pc_source = 2'b10; push(c, 0);
        end
    endtask

    // Runs one instruction from FETCH with random mem_ready and compares every cycle against plan().
    task automatic run_model(input logic [5:0] op);
        cw_t exp;
        bit  rdy;
        bit  adv;
        int  guard;
        plan(op);
        for (int i = 0; i < m_n; i++) begin
            adv   = 0;
            guard = 0;
            while (!adv) begin
                rdy = (guard > 6) ? 1'b1 : 1'($urandom_range(0, 1));
                go(rdy, (i == 0) ? 6'($urandom) : op);
                exp = m_step[i];
                if (i == 0 && !rdy) begin
                    exp.pc_write = 0;
                    exp.ir_write = 0;
                end
                check($sformatf("model op=%0h step=%0d", op, i), 32'(cw), 32'(exp));
                adv = !m_wait[i] || rdy;
                guard++;
                tick();
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int  cyc;
        int  rw;
        int  mw;
        int  il;
        bit  done;
        cyc = -1; rw = 0; mw = 0; il = 0; done = 0;
        for (int c = 0; c < 12 && !done; c++) begin
            go(1'b1, v.op);
            if (c > 0 && cw.ir_write) begin
                done = 1;
                cyc  = c;
                bus.mem_ready = 1'b0;  // park in FETCH for the next test
            end else begin
                rw += int'(cw.reg_write);
                mw += int'(cw.mem_write);
                il += int'(cw.illegal_op);
            end
            tick();
        end
        check($sformatf("latency op=%0h", v.op), 32'(cyc), 32'(v.lat));
        check($sformatf("reg_write op=%0h", v.op), 32'(rw), 32'(v.regw));
        check($sformatf("mem_write op=%0h", v.op), 32'(mw), 32'(v.memw));
        check($sformatf("illegal op=%0h", v.op), 32'(il), 32'(v.ill));
    endtask

    vec_t vt[14];
    logic [5:0] legal_ops[11];

    initial begin
        int rd_cnt;
        bit lw_rdy[7];

        vt[0]  = '{6'b000000, 4, 1, 0, 0};
        vt[1]  = '{6'b100011, 5, 1, 0, 0};
        vt[2]  = '{6'b101011, 4, 0, 1, 0};
        vt[3]  = '{6'b000100, 3, 0, 0, 0};
        vt[4]  = '{6'b000101, 3, 0, 0, 0};
        vt[5]  = '{6'b000111, 3, 0, 0, 0};
        vt[6]  = '{6'b001000, 4, 1, 0, 0};
        vt[7]  = '{6'b001010, 4, 1, 0, 0};
        vt[8]  = '{6'b001100, 4, 1, 0, 0};
        vt[9]  = '{6'b001101, 4, 1, 0, 0};
        vt[10] = '{6'b000010, 3, 0, 0, 0};
        vt[11] = '{6'b111111, 2, 0, 0, 1};
        vt[12] = '{6'b000001, 2, 0, 0, 1};
        vt[13] = '{6'b100000, 2, 0, 0, 1};
        legal_ops = '{6'd0, 6'd2, 6'd4, 6'd5, 6'd7, 6'd8, 6'd10, 6'd12, 6'd13, 6'd35, 6'd43};

        rst_n = 1'b0;
        bus.mem_ready = 1'b0;
        bus.opcode = '0;
        tick();
        go(1'b1, 6'h23);
        check("reset outputs ready=1", 32'(cw), 32'd0);
        tick();
        go(1'b0, 6'h00);
        check("reset outputs ready=0", 32'(cw), 32'd0);
        tick();
        rst_n = 1'b1;
        go(1'b0, 6'h00);
        check("first fetch stalled", 32'({cw.ir_write, cw.pc_write, cw.mem_read, cw.alu_src_b}), 32'(5'b00101));
        tick();

        foreach (vt[i]) run_vec(vt[i]);

        // lw with two stall cycles in MEM_READ
        lw_rdy = '{1, 1, 1, 0, 0, 1, 1};
        rd_cnt = 0;
        for (int c = 0; c < 7; c++) begin
            go(lw_rdy[c], 6'b100011);
            rd_cnt += int'(cw.iord & cw.mem_read);
            if (c == 6) check("lw MEM_WB", 32'({cw.reg_write, cw.mem_to_reg, cw.reg_dst}), 32'(3'b110));
            tick();
        end
        check("lw iord+mem_read cycles", 32'(rd_cnt), 32'd3);
        go(1'b0, 6'b100011);
        check("lw back in FETCH", 32'({cw.mem_read, cw.iord, cw.ir_write, cw.alu_src_b}), 32'(5'b10001));
        tick();

        // sw stalled in MEM_WRITE, then reset mid-stall
        go(1'b1, 6'b101011); tick();
        go(1'b1, 6'b101011); tick();
        go(1'b1, 6'b101011); tick();
        go(1'b0, 6'b101011);
        check("sw MEM_WRITE stall", 32'({cw.mem_write, cw.iord}), 32'(2'b11));
        tick();
        rst_n = 1'b0;
        go(1'b0, 6'b101011);
        check("sw reset forces zero", 32'(cw), 32'd0);
        tick();
        rst_n = 1'b1;
        go(1'b0, 6'b101011);
        check("post-reset fetch stall", 32'({cw.pc_write, cw.ir_write, cw.mem_read, cw.mem_write}), 32'(4'b0010));
        tick();
        go(1'b1, 6'b101011);
        check("post-reset fetch done", 32'({cw.pc_write, cw.ir_write}), 32'(2'b11));
        bus.mem_ready = 1'b0;
        tick();

        foreach (legal_ops[i]) run_model(legal_ops[i]);
        run_model(6'b111111);
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 9) == 0) run_model(6'($urandom));
            else run_model(legal_ops[$urandom_range(0, 10)]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
